// File: rtl/core_seq_if.sv
// Bus bundle between the tile sequencer and its surroundings (command, L0, PE core, OFIFO).
// A read strobe (rd_l0 / rd_ofifo) is only ever high in a cycle where the matching ready_l0 / o_valid is high; the transfer happens on that clock edge.
interface core_seq_if;
  logic       start;
  logic [7:0] n_tiles;
  logic       mode;
  logic       ready_l0;
  logic       o_valid;
  logic       rd_l0;
  logic [1:0] inst_w;
  logic       mode_o;
  logic       rd_ofifo;
  logic       busy;
  logic       done;
  logic [7:0] tile_idx;
  logic       err;
  logic [2:0] dbg_state;

  modport master (
    output start, n_tiles, mode, ready_l0, o_valid,
    input  rd_l0, inst_w, mode_o, rd_ofifo, busy, done, tile_idx, err, dbg_state
  );

  modport slave (
    input  start, n_tiles, mode, ready_l0, o_valid,
    output rd_l0, inst_w, mode_o, rd_ofifo, busy, done, tile_idx, err, dbg_state
  );
endinterface

// File: rtl/core_seq.sv
// core_seq: tile sequencer for a ROW x COL PE array (L0 -> PE core -> OFIFO).
// Optional DRAIN watchdog is compiled in with `define CORE_SEQ_TIMEOUT_EN.
module core_seq #(
  parameter int ROW = 4,
  parameter int COL = 4,
  parameter int LEN = 8,
  parameter int GAP = ROW + COL
) (
  input  logic      clk,
  input  logic      reset,
  core_seq_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_FLUSH  = 3'd2,
    S_EXEC   = 3'd3,
    S_DRAIN  = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  localparam logic [7:0] COL_LAST = 8'(COL - 1);
  localparam logic [7:0] ROW_LAST = 8'(ROW - 1);
  localparam logic [7:0] LEN_LAST = 8'(LEN - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] tile_q, tile_d;
  logic [7:0] ntiles_q, ntiles_d;
  logic       mode_q, mode_d;
  logic [1:0] inst_q, inst_d;
  logic       rd_l0;
  logic       rd_ofifo;
  logic       start_ok;
  logic       tile_last;
  logic [7:0] drain_last;
`ifdef CORE_SEQ_TIMEOUT_EN
  logic [9:0] wd_q, wd_d;
  logic       err_q, err_d;
`endif

  assign start_ok   = bus.start && (bus.n_tiles != 8'd0);
  // 9-bit compare so that n_tiles=255 finishes at tile 254 without wrapping.
  assign tile_last  = ({1'b0, tile_q} + 9'd1) == {1'b0, ntiles_q};
  assign drain_last = mode_q ? ROW_LAST : LEN_LAST;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tile_d   = tile_q;
    ntiles_d = ntiles_q;
    mode_d   = mode_q;
    rd_l0    = 1'b0;
    rd_ofifo = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          ntiles_d = bus.n_tiles;
          mode_d   = bus.mode;
          tile_d   = 8'd0;
          cnt_d    = 8'd0;
          state_d  = bus.mode ? S_EXEC : S_LOAD_W;
        end
      end
      S_LOAD_W: begin
        rd_l0 = bus.ready_l0;
        if (rd_l0) begin
          if (cnt_q == COL_LAST) begin
            cnt_d   = 8'd0;
            state_d = S_FLUSH;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      // Shared flush: after LOAD_W in WS mode, after EXEC in OS mode.
      S_FLUSH: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = 8'd0;
          state_d = mode_q ? S_DRAIN : S_EXEC;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_EXEC: begin
        rd_l0 = bus.ready_l0;
        if (rd_l0) begin
          if (cnt_q == LEN_LAST) begin
            cnt_d   = 8'd0;
            state_d = mode_q ? S_FLUSH : S_DRAIN;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_DRAIN: begin
        rd_ofifo = bus.o_valid;
        if (rd_ofifo) begin
          if (cnt_q == drain_last) begin
            cnt_d = 8'd0;
            if (tile_last) begin
              state_d = S_DONE;
            end else begin
              tile_d  = tile_q + 8'd1;
              state_d = mode_q ? S_EXEC : S_LOAD_W;
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase

`ifdef CORE_SEQ_TIMEOUT_EN
    wd_d  = wd_q;
    err_d = err_q;
    if (state_q == S_IDLE && start_ok) begin
      err_d = 1'b0;
    end
    if (state_q == S_DRAIN) begin
      if (rd_ofifo) begin
        wd_d = 10'd0;
      end else if (wd_q == 10'd1022) begin
        // Watchdog saturates: abort the command without a done pulse.
        wd_d    = 10'd1023;
        err_d   = 1'b1;
        cnt_d   = 8'd0;
        state_d = S_IDLE;
      end else begin
        wd_d = wd_q + 10'd1;
      end
    end else if (state_d == S_DRAIN) begin
      wd_d = 10'd0;
    end
`endif

    inst_d = {rd_l0 && (state_q == S_EXEC), rd_l0 && (state_q == S_LOAD_W)};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      tile_q   <= 8'd0;
      ntiles_q <= 8'd0;
      mode_q   <= 1'b0;
      inst_q   <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tile_q   <= tile_d;
      ntiles_q <= ntiles_d;
      mode_q   <= mode_d;
      inst_q   <= inst_d;
    end
  end

`ifdef CORE_SEQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_q  <= 10'd0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.rd_l0     = rd_l0;
  assign bus.rd_ofifo  = rd_ofifo;
  assign bus.inst_w    = inst_q;
  assign bus.mode_o    = mode_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.tile_idx  = tile_q;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_core_seq.sv
// Bench for core_seq: vector table, hand-written reset/ignore/timeout sequences,
// random commands checked against an event-queue model of the tile schedule.
module tb_core_seq;
  localparam int ROW = 4;
  localparam int COL = 4;
  localparam int LEN = 8;
  localparam int GAP = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  core_seq_if bus();

  core_seq #(.ROW(ROW), .COL(COL), .LEN(LEN), .GAP(GAP)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "global timeout");
  end

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // event = {kind[1:0], tile[7:0]}; kind 1 = kernel-load read, 2 = execute read, 3 = OFIFO read
  logic [9:0] exp_q[$];

  bit         mon_en = 1'b0;
  logic [1:0] prev_kind = 2'd0;
  int c_rd_l0, c_rd_of, c_i01, c_i10, c_busy, c_done, c_idle;

  always @(negedge clk) begin
    if (mon_en) begin
      logic [1:0] next_kind;
      logic [9:0] ev;
      next_kind = 2'd0;
      check("inst_w", int'(bus.inst_w), (prev_kind == 2'd1) ? 1 : (prev_kind == 2'd2) ? 2 : 0);
      if (bus.busy) c_busy++;
      if (bus.done) c_done++;
      if (bus.busy && !bus.done && !bus.rd_l0 && !bus.rd_ofifo) c_idle++;
      if (bus.inst_w == 2'b01) c_i01++;
      if (bus.inst_w == 2'b10) c_i10++;
      if (bus.rd_l0) check("rd_l0_needs_ready", int'(bus.ready_l0), 1);
      if (bus.rd_ofifo) check("rd_ofifo_needs_valid", int'(bus.o_valid), 1);
      if (bus.rd_l0 || bus.rd_ofifo) begin
        if (bus.rd_l0) c_rd_l0++;
        if (bus.rd_ofifo) c_rd_of++;
        if (exp_q.size() == 0) begin
          check("unexpected_read_pending", exp_q.size(), 1);
        end else begin
          ev = exp_q.pop_front();
          check("read_strobes", int'({bus.rd_l0, bus.rd_ofifo}), (ev[9:8] == 2'd3) ? 1 : 2);
          check("read_tile", int'(bus.tile_idx), int'(ev[7:0]));
          if (ev[9:8] != 2'd3) next_kind = ev[9:8];
        end
      end
      if (bus.done) check("done_events_left", exp_q.size(), 0);
      prev_kind = next_kind;
    end
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic md;
    int   n;
    int   l0_pct;
    int   ov_pct;
    bit   tog;
    int   inj;
    int   e_rd_l0;
    int   e_rd_of;
    int   e_i01;
    int   e_i10;
    int   e_busy;
    int   e_idle;
  } vec_t;

  vec_t vecs[8];

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_stall(input vec_t v, input int cyc);
    if (v.tog) bus.ready_l0 = cyc[0];
    else       bus.ready_l0 = ($urandom_range(99) >= v.l0_pct);
    bus.o_valid = ($urandom_range(99) >= v.ov_pct);
  endtask

  task automatic run_cmd(input vec_t v, input string tag);
    int cyc;
    exp_q.delete();
    for (int t = 0; t < v.n; t++) begin
      if (!v.md) for (int i = 0; i < COL; i++) exp_q.push_back({2'd1, 8'(t)});
      for (int i = 0; i < LEN; i++) exp_q.push_back({2'd2, 8'(t)});
      for (int i = 0; i < (v.md ? ROW : LEN); i++) exp_q.push_back({2'd3, 8'(t)});
    end
    c_rd_l0 = 0; c_rd_of = 0; c_i01 = 0; c_i10 = 0; c_busy = 0; c_done = 0; c_idle = 0;
    prev_kind = 2'd0;
    mon_en = 1'b1;
    bus.start   = 1'b1;
    bus.n_tiles = 8'(v.n);
    bus.mode    = v.md;
    drive_stall(v, 0);
    tick();
    bus.start   = 1'b0;
    bus.n_tiles = 8'($urandom);
    bus.mode    = 1'($urandom);
    cyc = 0;
    while (c_done == 0 && cyc < 20000) begin
      bus.start = 1'b0;
      drive_stall(v, cyc);
      if (v.inj > 0 && cyc == v.inj) begin
        bus.start   = 1'b1;
        bus.n_tiles = 8'd5;
        bus.mode    = ~v.md;
      end
      tick();
      cyc++;
    end
    bus.start = 1'b0;
    check({tag, "_done_seen"}, c_done, 1);
    tick();
    tick();
    mon_en = 1'b0;
    check({tag, "_done_pulses"}, c_done, 1);
    check({tag, "_busy_after"}, int'(bus.busy), 0);
    check({tag, "_events_left"}, exp_q.size(), 0);
    check({tag, "_rd_l0_total"}, c_rd_l0, v.e_rd_l0);
    check({tag, "_rd_ofifo_total"}, c_rd_of, v.e_rd_of);
    check({tag, "_inst_load_total"}, c_i01, v.e_i01);
    check({tag, "_inst_exec_total"}, c_i10, v.e_i10);
    if (v.e_busy >= 0) check({tag, "_busy_cycles"}, c_busy, v.e_busy);
    if (v.e_idle >= 0) check({tag, "_idle_cycles"}, c_idle, v.e_idle);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rd_l0"}, int'(bus.rd_l0), 0);
    check({tag, "_rd_ofifo"}, int'(bus.rd_ofifo), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_done"}, int'(bus.done), 0);
    check({tag, "_err"}, int'(bus.err), 0);
    check({tag, "_inst_w"}, int'(bus.inst_w), 0);
    check({tag, "_mode_o"}, int'(bus.mode_o), 0);
    check({tag, "_tile_idx"}, int'(bus.tile_idx), 0);
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t rv;
    int   busy_seen, done_seen, k, rdof_seen;

    //            md    n    l0  ov  tog   inj  rd_l0 rd_of i01  i10  busy  idle
    vecs[0] = '{1'b0, 1,   0,  0, 1'b0, 0,   12,   8,    4,   8,   29,   8};
    vecs[1] = '{1'b1, 2,   0,  0, 1'b0, 0,   16,   8,    0,   16,  41,   16};
    vecs[2] = '{1'b0, 3,   0,  0, 1'b1, 0,   36,   24,   12,  24,  -1,   -1};
    vecs[3] = '{1'b1, 1,   0,  0, 1'b0, 0,   8,    4,    0,   8,   21,   8};
    vecs[4] = '{1'b0, 2,   0,  0, 1'b0, 15,  24,   16,   8,   16,  57,   16};
    vecs[5] = '{1'b0, 2,   30, 30, 1'b0, 0,  24,   16,   8,   16,  -1,   -1};
    vecs[6] = '{1'b1, 3,   40, 25, 1'b0, 0,  24,   12,   0,   24,  -1,   -1};
    vecs[7] = '{1'b1, 255, 0,  0, 1'b0, 0,   2040, 1020, 0,   2040, 5101, 2040};

    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.n_tiles  = 8'd0;
    bus.mode     = 1'b0;
    bus.ready_l0 = 1'b1;
    bus.o_valid  = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check_reset_values("por");
    tick();
    reset = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      run_cmd(vecs[i], $sformatf("vec%0d", i));
    end

    // reset on the third EXEC read of an OS command
    bus.ready_l0 = 1'b1;
    bus.o_valid  = 1'b1;
    bus.start    = 1'b1;
    bus.n_tiles  = 8'd2;
    bus.mode     = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("midexec_third_read", int'(bus.rd_l0), 1);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("midexec_rst");
    tick();
    run_cmd(vecs[0], "after_rst");

    // start with n_tiles = 0 is ignored
    busy_seen = 0; done_seen = 0;
    bus.start   = 1'b1;
    bus.n_tiles = 8'd0;
    bus.mode    = 1'b0;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.busy) busy_seen++;
      if (bus.done) done_seen++;
    end
    check("zero_tiles_busy", busy_seen, 0);
    check("zero_tiles_done", done_seen, 0);

    // start coincident with reset is ignored
    tick();
    reset       = 1'b1;
    bus.start   = 1'b1;
    bus.n_tiles = 8'd3;
    tick();
    reset     = 1'b0;
    bus.start = 1'b0;
    busy_seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.busy) busy_seen++;
    end
    check("start_in_reset_busy", busy_seen, 0);

    // random commands against the schedule model
    for (int r = 0; r < 6; r++) begin
      rv.md      = 1'($urandom);
      rv.n       = $urandom_range(6, 1);
      rv.l0_pct  = $urandom_range(50, 0);
      rv.ov_pct  = $urandom_range(50, 0);
      rv.tog     = 1'b0;
      rv.inj     = 0;
      rv.e_rd_l0 = rv.n * (rv.md ? LEN : COL + LEN);
      rv.e_rd_of = rv.n * (rv.md ? ROW : LEN);
      rv.e_i01   = rv.md ? 0 : rv.n * COL;
      rv.e_i10   = rv.n * LEN;
      rv.e_busy  = -1;
      rv.e_idle  = -1;
      tick();
      run_cmd(rv, $sformatf("rnd%0d", r));
    end

    // DRAIN with o_valid held low
    tick();
    bus.ready_l0 = 1'b1;
    bus.o_valid  = 1'b0;
    bus.start    = 1'b1;
    bus.n_tiles  = 8'd1;
    bus.mode     = 1'b0;
    tick();
    bus.start = 1'b0;
    k = 0;
    while (bus.dbg_state != 3'd4 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("reach_drain", int'(k < 200), 1);
    k = 0; done_seen = 0; rdof_seen = 0;
    while (bus.err == 1'b0 && k < 1100) begin
      if (bus.done) done_seen++;
      if (bus.rd_ofifo) rdof_seen++;
      k++;
      @(negedge clk);
    end
    check("stall_rd_ofifo", rdof_seen, 0);
    check("stall_done", done_seen, 0);
`ifdef CORE_SEQ_TIMEOUT_EN
    check("timeout_cycles", k, 1023);
    check("timeout_err", int'(bus.err), 1);
    check("timeout_busy", int'(bus.busy), 0);
    @(negedge clk);
    check("timeout_no_done", int'(bus.done), 0);
    check("timeout_err_sticky", int'(bus.err), 1);
`else
    check("no_timeout_cycles", k, 1100);
    check("no_timeout_err", int'(bus.err), 0);
    check("no_timeout_busy", int'(bus.busy), 1);
`endif
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.o_valid = 1'b1;
    @(negedge clk);
    check_reset_values("final_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
